// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-outstanding arbiter for the shared memory port (fetch vs. load/store).
// Optional response watchdog is compiled in when MEM_ARB_TIMEOUT_EN is defined.
`default_nettype none

module mem_port_arbiter #(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            if_req_v_i,
   input  logic [XLEN-1:0] if_adr_i,
   output logic            if_gnt_o,
   output logic            if_rsp_v_o,
   output logic [XLEN-1:0] if_rsp_data_o,
   output logic            if_rsp_err_o,
   input  logic            lsu_req_v_i,
   input  logic [XLEN-1:0] lsu_adr_i,
   input  logic            lsu_is_store_i,
   input  logic [XLEN-1:0] lsu_store_data_i,
   input  logic [2:0]      lsu_access_size_i,
   output logic            lsu_gnt_o,
   output logic            lsu_rsp_v_o,
   output logic [XLEN-1:0] lsu_rsp_data_o,
   output logic            lsu_rsp_err_o,
   input  logic            flush_i,
   output logic            mem_req_v_o,
   output logic [XLEN-1:0] mem_adr_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [2:0]      mem_size_o,
   input  logic            mem_req_rdy_i,
   input  logic            mem_rsp_v_i,
   input  logic [XLEN-1:0] mem_rsp_data_i,
   input  logic            mem_rsp_err_i,
   output logic            busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   localparam logic [2:0] FETCH_SIZE = 3'b010;

   state_t          state;
   state_t          state_nxt;
   logic            last_gnt_lsu;
   logic            owner_lsu;
   logic            drop;
   logic [XLEN-1:0] adr_q;
   logic [XLEN-1:0] wdata_q;
   logic            we_q;
   logic [2:0]      size_q;

   logic            if_cand;
   logic            if_gnt;
   logic            lsu_gnt;
   logic            bus_rsp;
   logic            timeout;
   logic            rsp_evt;
   logic [XLEN-1:0] rsp_data;
   logic            rsp_err;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] cnt;

   // Held at zero while idle, so it starts from zero on every entry to REQ.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (state == IDLE)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   assign timeout = (state != IDLE) && (cnt == CNT_W'(TIMEOUT_CYCLES));
`else
   // Watchdog compiled out: never fires for any legal limit.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   // A flushed fetch is not a candidate, so the LSU is never blocked by it.
   assign if_cand = if_req_v_i && !flush_i;

   always_comb begin
      if_gnt    = 1'b0;
      lsu_gnt   = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            lsu_gnt = lsu_req_v_i && !(last_gnt_lsu && if_cand);
            if_gnt  = if_cand && !lsu_gnt;
            if (if_gnt || lsu_gnt)
               state_nxt = REQ;
         end
         REQ: begin
            if (timeout)
               state_nxt = IDLE;
            else if (mem_req_rdy_i)
               state_nxt = RSP;
         end
         RSP: begin
            if (bus_rsp || timeout)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus_rsp  = (state == RSP) && mem_rsp_v_i;
   assign rsp_evt  = bus_rsp || timeout;
   assign rsp_data = bus_rsp ? mem_rsp_data_i : '0;
   assign rsp_err  = bus_rsp ? mem_rsp_err_i : 1'b1;

   assign if_gnt_o      = if_gnt;
   assign lsu_gnt_o     = lsu_gnt;
   assign if_rsp_v_o    = rsp_evt && !owner_lsu && !drop && !flush_i;
   assign if_rsp_data_o = if_rsp_v_o ? rsp_data : '0;
   assign if_rsp_err_o  = if_rsp_v_o && rsp_err;
   assign lsu_rsp_v_o    = rsp_evt && owner_lsu;
   assign lsu_rsp_data_o = lsu_rsp_v_o ? rsp_data : '0;
   assign lsu_rsp_err_o  = lsu_rsp_v_o && rsp_err;

   assign mem_req_v_o = (state == REQ);
   assign mem_adr_o   = adr_q;
   assign mem_we_o    = we_q;
   assign mem_wdata_o = wdata_q;
   assign mem_size_o  = size_q;
   assign busy_o      = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         last_gnt_lsu <= 1'b0;
         owner_lsu    <= 1'b0;
         drop         <= 1'b0;
         adr_q        <= '0;
         wdata_q      <= '0;
         we_q         <= 1'b0;
         size_q       <= '0;
      end else begin
         state <= state_nxt;
         if (lsu_gnt) begin
            owner_lsu    <= 1'b1;
            last_gnt_lsu <= 1'b1;
            adr_q        <= lsu_adr_i;
            we_q         <= lsu_is_store_i;
            wdata_q      <= lsu_store_data_i;
            size_q       <= lsu_access_size_i;
         end else if (if_gnt) begin
            owner_lsu    <= 1'b0;
            last_gnt_lsu <= 1'b0;
            adr_q        <= if_adr_i;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            size_q       <= FETCH_SIZE;
         end
         // A flush anywhere in an IF-owned transaction poisons its response.
         if (state_nxt == IDLE)
            drop <= 1'b0;
         else if ((state != IDLE) && !owner_lsu && flush_i)
            drop <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed literal checks.
`default_nettype none

module tb_mem_port_arbiter;

   localparam int TO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic        clk, reset_n;
   logic        if_req_v_i, if_gnt_o, if_rsp_v_o, if_rsp_err_o;
   logic [31:0] if_adr_i, if_rsp_data_o;
   logic        lsu_req_v_i, lsu_is_store_i, lsu_gnt_o, lsu_rsp_v_o, lsu_rsp_err_o;
   logic [31:0] lsu_adr_i, lsu_store_data_i, lsu_rsp_data_o;
   logic [2:0]  lsu_access_size_i, mem_size_o;
   logic        flush_i, mem_req_v_o, mem_we_o, mem_req_rdy_i, mem_rsp_v_i, mem_rsp_err_i, busy_o;
   logic [31:0] mem_adr_o, mem_wdata_o, mem_rsp_data_i;

   mem_port_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req_v_i(if_req_v_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
      .if_rsp_v_o(if_rsp_v_o), .if_rsp_data_o(if_rsp_data_o), .if_rsp_err_o(if_rsp_err_o),
      .lsu_req_v_i(lsu_req_v_i), .lsu_adr_i(lsu_adr_i), .lsu_is_store_i(lsu_is_store_i),
      .lsu_store_data_i(lsu_store_data_i), .lsu_access_size_i(lsu_access_size_i),
      .lsu_gnt_o(lsu_gnt_o), .lsu_rsp_v_o(lsu_rsp_v_o), .lsu_rsp_data_o(lsu_rsp_data_o),
      .lsu_rsp_err_o(lsu_rsp_err_o), .flush_i(flush_i),
      .mem_req_v_o(mem_req_v_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
      .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o), .mem_req_rdy_i(mem_req_rdy_i),
      .mem_rsp_v_i(mem_rsp_v_i), .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_err_i(mem_rsp_err_i),
      .busy_o(busy_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bus responder configuration, set by the directed sequence.
   int          cfg_stall = 0;
   int          cfg_rdly  = 0;
   logic [31:0] cfg_data  = 32'h0;
   bit          cfg_err   = 1'b0;
   bit          cfg_norsp = 1'b0;

   initial begin : responder
      int stall_cnt, rd;
      bit waiting;
      mem_req_rdy_i = 1'b0; mem_rsp_v_i = 1'b0; mem_rsp_data_i = '0; mem_rsp_err_i = 1'b0;
      stall_cnt = 0; rd = 0; waiting = 1'b0;
      forever begin
         @(posedge clk); #1;
         mem_req_rdy_i = 1'b0; mem_rsp_v_i = 1'b0; mem_rsp_data_i = '0; mem_rsp_err_i = 1'b0;
         if (!reset_n) begin
            stall_cnt = 0; waiting = 1'b0;
         end else if (waiting) begin
            if (rd == 0) begin
               mem_rsp_v_i = 1'b1; mem_rsp_data_i = cfg_data; mem_rsp_err_i = cfg_err;
               waiting = 1'b0;
            end else rd--;
         end else if (mem_req_v_o) begin
            if (stall_cnt >= cfg_stall) begin
               mem_req_rdy_i = 1'b1; stall_cnt = 0; waiting = !cfg_norsp; rd = cfg_rdly;
            end else stall_cnt++;
         end
      end
   end

   // Transaction-level model: one transaction in flight, tracked as busy/sent/owner/dropped.
   bit          m_busy = 0, m_sent = 0, m_lsu = 0, m_last_lsu = 0, m_drop = 0, m_we = 0;
   logic [31:0] m_adr = 0, m_wdata = 0;
   logic [2:0]  m_size = 0;
   int          m_age = 0;
   int          if_rsp_cnt = 0, lsu_rsp_cnt = 0, lsu_err_cnt = 0;
   logic [31:0] last_if_data = 0, last_lsu_data = 0;

   always @(negedge clk) begin : compare
      bit          if_ok, e_lsug, e_ifg, e_bus, e_to, e_evt, e_ifv, e_lsuv, e_err;
      logic [31:0] e_data;
      if (!reset_n) begin
         m_busy = 0; m_sent = 0; m_lsu = 0; m_last_lsu = 0; m_drop = 0;
         m_we = 0; m_adr = 0; m_wdata = 0; m_size = 0; m_age = 0;
      end
      if_ok  = if_req_v_i && !flush_i;
      e_lsug = !m_busy && lsu_req_v_i && !(m_last_lsu && if_ok);
      e_ifg  = !m_busy && if_ok && !e_lsug;
      e_bus  = m_busy && m_sent && mem_rsp_v_i;
      e_to   = TO_EN && m_busy && (m_age == TO);
      e_evt  = e_bus || e_to;
      e_data = e_bus ? mem_rsp_data_i : 32'h0;
      e_err  = e_bus ? mem_rsp_err_i : 1'b1;
      e_ifv  = e_evt && !m_lsu && !m_drop && !flush_i;
      e_lsuv = e_evt && m_lsu;

      chk("if_gnt", if_gnt_o, e_ifg);
      chk("lsu_gnt", lsu_gnt_o, e_lsug);
      chk("mem_req_v", mem_req_v_o, m_busy && !m_sent);
      chk("mem_adr", mem_adr_o, m_adr);
      chk("mem_we", mem_we_o, m_we);
      chk("mem_wdata", mem_wdata_o, m_wdata);
      chk("mem_size", mem_size_o, m_size);
      chk("busy", busy_o, m_busy);
      chk("if_rsp_v", if_rsp_v_o, e_ifv);
      chk("if_rsp_data", if_rsp_data_o, e_ifv ? e_data : 32'h0);
      chk("if_rsp_err", if_rsp_err_o, e_ifv && e_err);
      chk("lsu_rsp_v", lsu_rsp_v_o, e_lsuv);
      chk("lsu_rsp_data", lsu_rsp_data_o, e_lsuv ? e_data : 32'h0);
      chk("lsu_rsp_err", lsu_rsp_err_o, e_lsuv && e_err);

      if (if_rsp_v_o)  begin if_rsp_cnt++;  last_if_data  = if_rsp_data_o; end
      if (lsu_rsp_v_o) begin lsu_rsp_cnt++; last_lsu_data = lsu_rsp_data_o; end
      if (lsu_rsp_v_o && lsu_rsp_err_o) lsu_err_cnt++;

      if (reset_n) begin
         if (m_busy) begin
            if (flush_i && !m_lsu) m_drop = 1;
            if (e_evt) begin m_busy = 0; m_drop = 0; end
            else if (!m_sent && mem_req_rdy_i) m_sent = 1;
            m_age++;
         end else if (e_lsug || e_ifg) begin
            m_busy = 1; m_sent = 0; m_age = 0; m_lsu = e_lsug; m_last_lsu = e_lsug;
            m_adr   = e_lsug ? lsu_adr_i : if_adr_i;
            m_we    = e_lsug ? lsu_is_store_i : 1'b0;
            m_wdata = e_lsug ? lsu_store_data_i : 32'h0;
            m_size  = e_lsug ? lsu_access_size_i : 3'b010;
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wait_gnt(input bit lsu);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = lsu ? lsu_gnt_o : if_gnt_o;
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL grant_wait: no grant within 50 cycles (lsu=%0d)", lsu);
      end
   endtask

   task automatic wait_idle();
      bit idle;
      idle = 1'b0;
      for (int i = 0; i < 60 && !idle; i++) begin
         @(negedge clk);
         idle = !busy_o;
      end
      if (!idle) begin
         n_cmp++; n_bad++;
         $display("FAIL idle_wait: still busy after 60 cycles");
      end
   endtask

   // One complete transaction; flush_i pulses for one cycle k cycles after the grant.
   task automatic run_txn(input bit lsu, input logic [31:0] adr, input bit st,
                          input logic [31:0] wd, input int stall, input int rdly,
                          input logic [31:0] rdata, input bit rerr, input bit norsp,
                          input int flush_at);
      int k;
      cfg_stall = stall; cfg_rdly = rdly; cfg_data = rdata; cfg_err = rerr; cfg_norsp = norsp;
      if (lsu) begin
         lsu_req_v_i = 1'b1; lsu_adr_i = adr; lsu_is_store_i = st;
         lsu_store_data_i = wd; lsu_access_size_i = 3'b010;
      end else begin
         if_req_v_i = 1'b1; if_adr_i = adr;
      end
      wait_gnt(lsu);
      k = 0;
      do begin
         step();
         if_req_v_i = 1'b0; lsu_req_v_i = 1'b0;
         k++;
         flush_i = (k == flush_at);
         @(negedge clk);
      end while (busy_o && k < 60);
      if (busy_o) begin
         n_cmp++; n_bad++;
         $display("FAIL txn_wait: transaction not finished after 60 cycles");
      end
      step();
      flush_i = 1'b0;
   endtask

   initial begin : main
      int nlog, b_if, b_lsu, b_err;
      bit glog [4];
      bit exp_order [4];
      exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
      reset_n = 1'b0; flush_i = 1'b0;
      if_req_v_i = 1'b0; if_adr_i = '0;
      lsu_req_v_i = 1'b0; lsu_adr_i = '0; lsu_is_store_i = 1'b0;
      lsu_store_data_i = '0; lsu_access_size_i = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", busy_o, 1'b0);
      chk("reset_mem_req_v", mem_req_v_o, 1'b0);
      chk("reset_mem_adr", mem_adr_o, 32'h0);
      chk("reset_rsp_v", {if_rsp_v_o, lsu_rsp_v_o, if_rsp_err_o, lsu_rsp_err_o}, 4'h0);
      reset_n = 1'b1;
      step();

      // Both requesters held from reset: LSU first, then alternating.
      cfg_stall = 0; cfg_rdly = 0; cfg_data = 32'h0; cfg_err = 1'b0; cfg_norsp = 1'b0;
      if_req_v_i = 1'b1; if_adr_i = 32'h40;
      lsu_req_v_i = 1'b1; lsu_adr_i = 32'h800; lsu_access_size_i = 3'b010;
      nlog = 0;
      for (int i = 0; i < 40 && nlog < 4; i++) begin
         @(negedge clk);
         if (lsu_gnt_o) begin glog[nlog] = 1'b1; nlog++; end
         else if (if_gnt_o) begin glog[nlog] = 1'b0; nlog++; end
      end
      step();
      if_req_v_i = 1'b0; lsu_req_v_i = 1'b0;
      wait_idle();
      chk("contention_grants", nlog, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("contention_order%0d", i), glog[i], exp_order[i]);

      // Single fetch: grant c0, request c1, response c2, idle c3.
      step();
      cfg_data = 32'hDEADBEEF;
      if_req_v_i = 1'b1; if_adr_i = 32'h100;
      wait_gnt(1'b0);
      step();
      if_req_v_i = 1'b0;
      @(negedge clk);
      chk("fetch_req_v_c1", mem_req_v_o, 1'b1);
      chk("fetch_adr_c1", mem_adr_o, 32'h100);
      chk("fetch_size_c1", mem_size_o, 3'b010);
      chk("fetch_we_c1", mem_we_o, 1'b0);
      @(negedge clk);
      chk("fetch_rsp_v_c2", if_rsp_v_o, 1'b1);
      chk("fetch_rsp_data_c2", if_rsp_data_o, 32'hDEADBEEF);
      chk("fetch_lsu_quiet_c2", lsu_rsp_v_o, 1'b0);
      @(negedge clk);
      chk("fetch_busy_c3", busy_o, 1'b0);
      step();

      // Store with three stall cycles: request held stable for four cycles.
      cfg_stall = 3; cfg_data = 32'h0;
      lsu_req_v_i = 1'b1; lsu_adr_i = 32'h2004; lsu_is_store_i = 1'b1;
      lsu_store_data_i = 32'h55AA; lsu_access_size_i = 3'b010;
      wait_gnt(1'b1);
      step();
      lsu_req_v_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("store_hold%0d", i),
             {mem_req_v_o, mem_we_o, mem_size_o, mem_adr_o, mem_wdata_o},
             {1'b1, 1'b1, 3'b010, 32'h2004, 32'h55AA});
      end
      @(negedge clk);
      chk("store_lsu_rsp_v", lsu_rsp_v_o, 1'b1);
      chk("store_if_rsp_v", if_rsp_v_o, 1'b0);
      wait_idle();
      step();
      lsu_is_store_i = 1'b0; cfg_stall = 0;

      // Load with bus error.
      b_lsu = lsu_rsp_cnt; b_err = lsu_err_cnt;
      run_txn(1'b1, 32'h3000, 1'b0, 32'h0, 0, 1, 32'h0000BAD0, 1'b1, 1'b0, -1);
      chk("err_lsu_rsp", lsu_rsp_cnt - b_lsu, 1);
      chk("err_lsu_err", lsu_err_cnt - b_err, 1);

      // Flush during a fetch in RSP, then on the response cycle itself.
      b_if = if_rsp_cnt;
      run_txn(1'b0, 32'h200, 1'b0, 32'h0, 0, 2, 32'hAAAA5555, 1'b0, 1'b0, 2);
      chk("flush_rsp_dropped", if_rsp_cnt - b_if, 0);
      b_if = if_rsp_cnt;
      run_txn(1'b0, 32'h204, 1'b0, 32'h0, 0, 2, 32'hBBBB6666, 1'b0, 1'b0, 4);
      chk("flush_rsp_cycle_dropped", if_rsp_cnt - b_if, 0);
      b_if = if_rsp_cnt;
      run_txn(1'b0, 32'h208, 1'b0, 32'h0, 1, 1, 32'h12345678, 1'b0, 1'b0, -1);
      chk("refetch_rsp", if_rsp_cnt - b_if, 1);
      chk("refetch_data", last_if_data, 32'h12345678);
      b_lsu = lsu_rsp_cnt;
      run_txn(1'b1, 32'h4000, 1'b0, 32'h0, 0, 2, 32'hCAFEF00D, 1'b0, 1'b0, 2);
      chk("flush_lsu_kept", lsu_rsp_cnt - b_lsu, 1);
      chk("flush_lsu_data", last_lsu_data, 32'hCAFEF00D);

      // Reset in the middle of a fetch response wait.
      cfg_stall = 0; cfg_rdly = 6; cfg_data = 32'h0; cfg_err = 1'b0;
      if_req_v_i = 1'b1; if_adr_i = 32'h300;
      wait_gnt(1'b0);
      step();
      if_req_v_i = 1'b0;
      step();
      chk("pre_reset_busy", busy_o, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("midreset_busy", busy_o, 1'b0);
      chk("midreset_mem", {mem_req_v_o, mem_we_o, mem_size_o, mem_adr_o, mem_wdata_o}, 69'h0);
      chk("midreset_rsp", {if_rsp_v_o, lsu_rsp_v_o, if_rsp_err_o, lsu_rsp_err_o}, 4'h0);
      step();
      step();
      reset_n = 1'b1;
      step();

`ifdef MEM_ARB_TIMEOUT_EN
      // No bus response: watchdog answers the LSU with an error and zero data.
      b_lsu = lsu_rsp_cnt; b_err = lsu_err_cnt;
      run_txn(1'b1, 32'h5000, 1'b0, 32'h0, 0, 0, 32'h0, 1'b0, 1'b1, -1);
      chk("timeout_lsu_rsp", lsu_rsp_cnt - b_lsu, 1);
      chk("timeout_lsu_err", lsu_err_cnt - b_err, 1);
      chk("timeout_lsu_data", last_lsu_data, 32'h0);
      cfg_norsp = 1'b0;
`endif

      repeat (3) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
